// File: rtl/pixel_packer_pkg.sv
// -----------------------------------------------------------------------------
// pixel_packer_pkg
// Shared definitions for the pixel packer slice: stream widths, the FIFO entry
// layout (data + tlast + tuser) and the grey-to-8-bit expansion helper.
// -----------------------------------------------------------------------------
package pixel_packer_pkg;

   localparam int unsigned COLOR_WIDTH     = 8;
   localparam int unsigned AXIS_DATA_WIDTH = 32;
   localparam int unsigned RGB_WIDTH       = 24;

   // One queued output word: 32-bit data plus its AXI-S sidebands (34 bits).
   typedef struct packed {
      logic [AXIS_DATA_WIDTH-1:0] data;
      logic                       last;
      logic                       user;
   } axis_word_t;

   // Position of the incoming pixel within a 4-pixel / 3-word packing group.
   typedef enum logic [1:0] {
      PH0 = 2'd0,
      PH1 = 2'd1,
      PH2 = 2'd2,
      PH3 = 2'd3
   } phase_e;

   // MSB-align the shade into 8 bits: wider shades are truncated, narrower
   // shades are zero-padded at the bottom.
   function automatic logic [7:0] shade_to_grey(input logic [COLOR_WIDTH-1:0] s);
      logic [COLOR_WIDTH+7:0] wide;
      wide = {s, 8'h00};
      return wide[COLOR_WIDTH+7 -: 8];
   endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// -----------------------------------------------------------------------------
// sync_fifo_fwft
// Single-clock first-word-fall-through FIFO. dout always shows the head entry
// while empty is low. A push while full is accepted only if a pop happens in
// the same cycle; otherwise it is ignored (the caller decides what that means).
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (empties the FIFO)
//   push, din   write request and data
//   pop         read request (ignored while empty)
//   dout        head entry
//   full, empty status, from (log2(DEPTH)+1)-bit wrap-around pointers
// -----------------------------------------------------------------------------
module sync_fifo_fwft #(
   parameter int unsigned WIDTH = 34,
   parameter int unsigned DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wptr_q, wptr_d;
   logic [AW:0]      rptr_q, rptr_d;
   logic             do_push, do_pop;

   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                  (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

   assign do_pop  = pop && !empty;
   // A simultaneous pop frees the slot, so a push into a full FIFO succeeds.
   assign do_push = push && (!full || do_pop);

   assign dout = mem_q[rptr_q[AW-1:0]];

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (do_push) wptr_d = wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_d = rptr_q + (AW+1)'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/pixel_packer.sv
// -----------------------------------------------------------------------------
// pixel_packer
// Tail of the ray-marcher shading path. Takes one grey shade per valid cycle,
// tracks raster position, expands each shade to RGB888 ({g,g,g}) and packs four
// pixels into three little-endian 32-bit words. Words are queued in a FWFT FIFO
// and leave as an AXI4-Stream (tuser = first word of frame, tlast = last word
// of line). The shading side has no ready, so a full FIFO drops the word and
// sets the sticky overflow flag.
// Optional feature: define PIXEL_PACKER_TEST_PATTERN_EN to add the test_pattern
// input, which replaces each grey value with x[7:0] (horizontal ramp).
// Ports:
//   clk, rst_gen_n       clock, asynchronous active-low reset
//   valid_in, shade_in   shade stream, one pixel per valid cycle
//   frame_start          resynchronise raster position to (0,0)
//   clr_overflow         clear the sticky overflow flag
//   m_axis_*             AXI4-Stream master (tdata/tvalid/tready/tlast/tuser)
//   overflow             sticky word-dropped flag
//   frame_done           one-cycle pulse after the last pixel of a frame
// -----------------------------------------------------------------------------
module pixel_packer
   import pixel_packer_pkg::*;
#(
   parameter int unsigned WIDTH      = 640,
   parameter int unsigned HEIGHT     = 480,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_gen_n,
   input  logic                       valid_in,
   input  logic [COLOR_WIDTH-1:0]     shade_in,
   input  logic                       frame_start,
   input  logic                       clr_overflow,
`ifdef PIXEL_PACKER_TEST_PATTERN_EN
   input  logic                       test_pattern,
`endif
   output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
   output logic                       m_axis_tvalid,
   input  logic                       m_axis_tready,
   output logic                       m_axis_tlast,
   output logic                       m_axis_tuser,
   output logic                       overflow,
   output logic                       frame_done
);

   localparam int unsigned XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
   localparam int unsigned YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

   logic [XW-1:0]        x_q, x_d, x_eff;
   logic [YW-1:0]        y_q, y_d, y_eff;
   phase_e               ph_q, ph_d, ph_eff;
   logic [RGB_WIDTH-1:0] hold_q, hold_d;
   logic                 sof_q, sof_d;
   axis_word_t           word_q, word_d;
   logic                 push_q, push_d;
   logic                 fd_q, fd_d;
   logic                 ovf_q, ovf_d;

   logic [7:0]           g;
   logic [RGB_WIDTH-1:0] p;

   axis_word_t           head;
   logic                 fifo_full, fifo_empty, pop;

   // frame_start takes effect in the same cycle, so a coincident pixel is
   // processed as (0,0) at phase 0.
   always_comb begin
      x_eff  = frame_start ? '0  : x_q;
      y_eff  = frame_start ? '0  : y_q;
      ph_eff = frame_start ? PH0 : ph_q;
   end

`ifdef PIXEL_PACKER_TEST_PATTERN_EN
   assign g = test_pattern ? 8'(x_eff) : shade_to_grey(shade_in);
`else
   assign g = shade_to_grey(shade_in);
`endif
   assign p = {g, g, g};

   always_comb begin
      x_d    = x_eff;
      y_d    = y_eff;
      ph_d   = ph_eff;
      hold_d = hold_q;
      sof_d  = sof_q;
      word_d = word_q;
      push_d = 1'b0;
      fd_d   = 1'b0;

      if (valid_in) begin
         // Packing: the hold register carries the bytes of the previous pixel
         // that did not fit into the word just completed.
         case (ph_eff)
            PH0: begin
               hold_d = p;
               sof_d  = (y_eff == '0) && (x_eff == '0);
               ph_d   = PH1;
            end
            PH1: begin
               word_d = '{data: {p[7:0], hold_q}, last: 1'b0, user: sof_q};
               push_d = 1'b1;
               hold_d = {8'h00, p[23:8]};
               ph_d   = PH2;
            end
            PH2: begin
               word_d = '{data: {p[15:0], hold_q[15:0]}, last: 1'b0, user: 1'b0};
               push_d = 1'b1;
               hold_d = {16'h0000, p[23:16]};
               ph_d   = PH3;
            end
            default: begin
               word_d = '{data: {p, hold_q[7:0]}, last: (x_eff == X_LAST), user: 1'b0};
               push_d = 1'b1;
               ph_d   = PH0;
            end
         endcase

         if (x_eff == X_LAST) begin
            x_d = '0;
            if (y_eff == Y_LAST) begin
               y_d  = '0;
               fd_d = 1'b1;
            end else begin
               y_d = y_eff + YW'(1);
            end
         end else begin
            x_d = x_eff + XW'(1);
         end
      end
   end

   assign pop = m_axis_tvalid && m_axis_tready;

   // Set wins over clear.
   always_comb begin
      ovf_d = ovf_q;
      if (clr_overflow) ovf_d = 1'b0;
      if (push_q && fifo_full && !pop) ovf_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_gen_n) begin
      if (!rst_gen_n) begin
         x_q    <= '0;
         y_q    <= '0;
         ph_q   <= PH0;
         hold_q <= '0;
         sof_q  <= 1'b0;
         word_q <= '0;
         push_q <= 1'b0;
         fd_q   <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         x_q    <= x_d;
         y_q    <= y_d;
         ph_q   <= ph_d;
         hold_q <= hold_d;
         sof_q  <= sof_d;
         word_q <= word_d;
         push_q <= push_d;
         fd_q   <= fd_d;
         ovf_q  <= ovf_d;
      end
   end

   sync_fifo_fwft #(
      .WIDTH ($bits(axis_word_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_gen_n),
      .push  (push_q),
      .pop   (pop),
      .din   (word_q),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Head entry is masked while empty so the stream reads all-zero after reset.
   assign m_axis_tvalid = !fifo_empty;
   assign m_axis_tdata  = m_axis_tvalid ? head.data : '0;
   assign m_axis_tlast  = m_axis_tvalid && head.last;
   assign m_axis_tuser  = m_axis_tvalid && head.user;
   assign overflow      = ovf_q;
   assign frame_done    = fd_q;

endmodule

// File: tb/tb_pixel_packer.sv
module tb_pixel_packer;
   import pixel_packer_pkg::*;

   logic                   clk = 1'b0;
   logic                   rst_gen_n;
   logic                   valid_in;
   logic [COLOR_WIDTH-1:0] shade_in;
   logic                   frame_start;
   logic                   clr_overflow;
`ifdef PIXEL_PACKER_TEST_PATTERN_EN
   logic                   test_pattern;
`endif
   logic [31:0]            m_axis_tdata;
   logic                   m_axis_tvalid;
   logic                   m_axis_tready;
   logic                   m_axis_tlast;
   logic                   m_axis_tuser;
   logic                   overflow;
   logic                   frame_done;

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;
   int unsigned fd_cnt  = 0;
   int unsigned fd_base;
   logic [33:0] got[$];   // {tlast, tuser, tdata} of each handshaken word

   pixel_packer #(
      .WIDTH      (8),
      .HEIGHT     (2),
      .FIFO_DEPTH (4)
   ) dut (
      .clk           (clk),
      .rst_gen_n     (rst_gen_n),
      .valid_in      (valid_in),
      .shade_in      (shade_in),
      .frame_start   (frame_start),
      .clr_overflow  (clr_overflow),
`ifdef PIXEL_PACKER_TEST_PATTERN_EN
      .test_pattern  (test_pattern),
`endif
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tuser  (m_axis_tuser),
      .overflow      (overflow),
      .frame_done    (frame_done)
   );

   always #5 clk = ~clk;

   // Capture every handshake and frame_done pulse mid-cycle.
   always @(negedge clk) begin
      if (rst_gen_n) begin
         if (m_axis_tvalid && m_axis_tready)
            got.push_back({m_axis_tlast, m_axis_tuser, m_axis_tdata});
         if (frame_done) fd_cnt++;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic feed(input logic [7:0] first, input int unsigned n, input logic fs);
      for (int unsigned i = 0; i < n; i++) begin
         valid_in    = 1'b1;
         shade_in    = first + 8'(i);
         frame_start = fs && (i == 0);
         @(posedge clk); #1;
      end
      valid_in    = 1'b0;
      frame_start = 1'b0;
   endtask

   task automatic idle(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reference packer: grey values base, base+1, ... form a byte stream of
   // three bytes per pixel; word k is bytes 4k..4k+3 little-endian.
   function automatic logic [31:0] pack_word(input int unsigned k, input logic [7:0] base);
      logic [31:0] w;
      for (int unsigned b = 0; b < 4; b++)
         w[8*b +: 8] = base + 8'((4*k + b) / 3);
      return w;
   endfunction

   function automatic logic [33:0] ent(input logic last, input logic user, input logic [31:0] d);
      return {last, user, d};
   endfunction

   initial begin
      rst_gen_n     = 1'b0;
      valid_in      = 1'b0;
      shade_in      = '0;
      frame_start   = 1'b0;
      clr_overflow  = 1'b0;
      m_axis_tready = 1'b1;
`ifdef PIXEL_PACKER_TEST_PATTERN_EN
      test_pattern  = 1'b0;
`endif
      idle(3);

      // Reset state
      check("rst_tvalid",     m_axis_tvalid, 0);
      check("rst_tdata",      m_axis_tdata,  0);
      check("rst_tlast",      m_axis_tlast,  0);
      check("rst_tuser",      m_axis_tuser,  0);
      check("rst_overflow",   overflow,      0);
      check("rst_frame_done", frame_done,    0);
      rst_gen_n = 1'b1;
      idle(2);

      // Basic packing of shades 1..4, with first-word latency
      valid_in = 1'b1; shade_in = 8'h01; @(posedge clk); #1;
      shade_in = 8'h02; @(posedge clk); #1;
      check("lat_not_yet", m_axis_tvalid, 0);
      shade_in = 8'h03; @(posedge clk); #1;
      check("lat_tvalid", m_axis_tvalid, 1);
      check("lat_word0",  {m_axis_tlast, m_axis_tuser, m_axis_tdata}, ent(0, 1, 32'h02010101));
      shade_in = 8'h04; @(posedge clk); #1;
      valid_in = 1'b0;
      idle(5);
      check("s1_count", got.size(), 3);
      check("s1_w0", got[0], ent(0, 1, 32'h02010101));
      check("s1_w1", got[1], ent(0, 0, 32'h03030202));
      check("s1_w2", got[2], ent(0, 0, 32'h04040403));

      // Full 8x2 frame of shades 1..16, then the start of the next frame
      got.delete();
      fd_base = fd_cnt;
      feed(8'h01, 16, 1'b1);
      check("fd_pulse", frame_done, 1);
      idle(1);
      check("fd_single_cycle", frame_done, 0);
      idle(4);
      check("frame_count", got.size(), 12);
      for (int unsigned k = 0; k < 12; k++)
         check($sformatf("frame_w%0d", k + 1), got[k],
               ent((k == 5) || (k == 11), k == 0, pack_word(k, 8'h01)));
      check("fd_count", fd_cnt - fd_base, 1);
      got.delete();
      feed(8'h21, 4, 1'b0);
      idle(4);
      check("next_frame_w0", got[0], ent(0, 1, 32'h22212121));

      // Backpressure overflow with a 4-deep FIFO
      got.delete();
      m_axis_tready = 1'b0;
      feed(8'h31, 8, 1'b1);
      idle(3);
      check("ovf_set",       overflow,      1);
      check("ovf_held_vld",  m_axis_tvalid, 1);
      check("ovf_held_head", {m_axis_tlast, m_axis_tuser, m_axis_tdata}, ent(0, 1, pack_word(0, 8'h31)));
      m_axis_tready = 1'b1;
      idle(8);
      check("ovf_drain_count", got.size(), 4);
      for (int unsigned k = 0; k < 4; k++)
         check($sformatf("ovf_w%0d", k + 1), got[k], ent(0, k == 0, pack_word(k, 8'h31)));
      check("ovf_sticky", overflow, 1);
      clr_overflow = 1'b1; @(posedge clk); #1;
      clr_overflow = 1'b0;
      check("ovf_cleared", overflow, 0);

      // frame_start coincident with the 3rd pixel
      got.delete();
      feed(8'h0A, 2, 1'b1);
      feed(8'h10, 4, 1'b1);
      idle(5);
      check("fs_count", got.size(), 4);
      check("fs_w0", got[0], ent(0, 1, 32'h0B0A0A0A));
      check("fs_w1", got[1], ent(0, 1, 32'h11101010));
      check("fs_w2", got[2], ent(0, 0, 32'h12121111));
      check("fs_w3", got[3], ent(0, 0, 32'h13131312));

      // Asynchronous reset mid-line with words queued
      got.delete();
      m_axis_tready = 1'b0;
      feed(8'h40, 6, 1'b1);
      idle(2);
      check("pre_rst_tvalid", m_axis_tvalid, 1);
      #2 rst_gen_n = 1'b0;
      #1;
      check("async_rst_tvalid", m_axis_tvalid, 0);
      check("async_rst_tdata",  m_axis_tdata,  0);
      idle(2);
      rst_gen_n     = 1'b1;
      m_axis_tready = 1'b1;
      idle(1);
      check("post_rst_empty", m_axis_tvalid, 0);
      feed(8'h01, 4, 1'b0);
      idle(5);
      check("rst_rep_count", got.size(), 3);
      check("rst_rep_w0", got[0], ent(0, 1, 32'h02010101));
      check("rst_rep_w1", got[1], ent(0, 0, 32'h03030202));
      check("rst_rep_w2", got[2], ent(0, 0, 32'h04040403));

`ifdef PIXEL_PACKER_TEST_PATTERN_EN
      // Horizontal ramp replaces the shade
      got.delete();
      test_pattern = 1'b1;
      feed(8'hAA, 4, 1'b1);
      test_pattern = 1'b0;
      idle(5);
      check("tp_w0", got[0], ent(0, 1, 32'h01000000));
      check("tp_w1", got[1], ent(0, 0, 32'h02020101));
      check("tp_w2", got[2], ent(0, 0, 32'h03030302));
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
